// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_counter
// Description : Free-running BCD time-of-day counter (HH:MM:SS, 00:00:00 to
//               23:59:59). It has an internal prescaler that produces a 1 Hz
//               advance, a setting-mode freeze (set_en) and a one-cycle load
//               port. The optional macro VALIDATE_EN rejects loads that
//               contain out-of-range fields and pulses load_err when it does.
// Revision    : 1.0 - initial release
// ============================================================================
module time_counter #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic       set_load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] cur_hh,
    output logic [7:0] cur_mm,
    output logic [7:0] cur_ss,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err
);

    localparam int              c_PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRES_MAX = c_PW'(CLK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRES_ONE = c_PW'(1);

    // A field is legal when both nibbles are decimal and the value is <= its max.
    function automatic logic field_ok(input logic [7:0] v, input logic [7:0] maxv);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= maxv);
    endfunction

    // One BCD step of a field, returned as {carry, next}. A field at its max,
    // or holding an illegal value, rolls over to 00 and carries.
    function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] maxv);
        if (!field_ok(v, maxv) || (v == maxv)) begin
            return {1'b1, 8'h00};
        end
        if (v[3:0] == 4'd9) begin
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        end
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [c_PW-1:0] r_pres;
    logic [7:0]      r_hh;
    logic [7:0]      r_mm;
    logic [7:0]      r_ss;
    logic            r_tick;
    logic            r_day;

    logic [8:0]      w_ss_step;
    logic [8:0]      w_mm_step;
    logic [8:0]      w_hh_step;
    logic [7:0]      w_adv_mm;
    logic [7:0]      w_adv_hh;
    logic            w_adv_day;
    logic            w_pres_wrap;
    logic            w_load_ok;
    logic            w_accept;

    // The complete seconds/minutes/hours ripple is resolved combinationally, so
    // a carry chain such as 23:59:59 -> 00:00:00 settles on a single edge.
    always_comb begin
        w_ss_step = bcd_step(r_ss, 8'h59);
        w_mm_step = bcd_step(r_mm, 8'h59);
        w_hh_step = bcd_step(r_hh, 8'h23);
        w_adv_mm  = w_ss_step[8] ? w_mm_step[7:0] : r_mm;
        w_adv_hh  = (w_ss_step[8] && w_mm_step[8]) ? w_hh_step[7:0] : r_hh;
        w_adv_day = w_ss_step[8] && w_mm_step[8] && w_hh_step[8];
    end

    assign w_pres_wrap = !set_en && (r_pres == c_PRES_MAX);

`ifdef VALIDATE_EN
    assign w_load_ok = field_ok(set_hh, 8'h23) && field_ok(set_mm, 8'h59) &&
                       field_ok(set_ss, 8'h59);
`else
    assign w_load_ok = 1'b1;
`endif

    assign w_accept = set_load && w_load_ok;

    // Prescaler and time registers. An accepted load has priority over a
    // coincident wrap, and that advance is dropped. Setting mode holds the
    // prescaler at zero, so the first advance after release comes CLK_DIV
    // edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pres <= '0;
            r_hh   <= 8'h00;
            r_mm   <= 8'h00;
            r_ss   <= 8'h00;
            r_tick <= 1'b0;
            r_day  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_day  <= 1'b0;
            if (w_accept) begin
                r_pres <= '0;
                r_hh   <= set_hh;
                r_mm   <= set_mm;
                r_ss   <= set_ss;
            end else if (set_en) begin
                r_pres <= '0;
            end else if (w_pres_wrap) begin
                r_pres <= '0;
                r_ss   <= w_ss_step[7:0];
                r_mm   <= w_adv_mm;
                r_hh   <= w_adv_hh;
                r_tick <= 1'b1;
                r_day  <= w_adv_day;
            end else begin
                r_pres <= r_pres + c_PRES_ONE;
            end
        end
    end

`ifdef VALIDATE_EN
    logic r_load_err;

    // A rejected load leaves time and prescaler untouched and only flags the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= set_load && !w_load_ok;
        end
    end

    assign load_err = r_load_err;
`else
    assign load_err = 1'b0;
`endif

    assign cur_hh   = r_hh;
    assign cur_mm   = r_mm;
    assign cur_ss   = r_ss;
    assign sec_tick = r_tick;
    assign day_wrap = r_day;

endmodule
`default_nettype wire
